// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mul_seq_ctrl
// Description : 32x32 unsigned multiply sequenced over one shared registered
//               16x16 cell. Define MUL_SEQ_HIGH_EN for the full 64-bit product.
// Revision    : 1.0  initial release
// ============================================================================
module mul_seq_ctrl #(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_lo,
  output logic [31:0] out_hi,
  output logic        busy,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  output logic        mul_en,
  input  logic [31:0] mul_p
);

`ifdef MUL_SEQ_HIGH_EN
  localparam int         ACC_W     = 64;
  localparam logic [1:0] LAST_STEP = 2'd3;
`else
  localparam int         ACC_W     = 32;
  localparam logic [1:0] LAST_STEP = 2'd2;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [1:0]       step;
  logic [ACC_W-1:0] acc;
  logic             tag_v [MUL_LATENCY];
  logic [1:0]       tag_k [MUL_LATENCY];
  logic             pending;
  logic [ACC_W-1:0] addend;

  // Returns {cell A, cell B} for a given partial-product step.
  function automatic logic [31:0] pick(input logic [1:0] s,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
    case (s)
      2'd0:    pick = {a[15:0],  b[15:0]};
      2'd1:    pick = {a[15:0],  b[31:16]};
      2'd2:    pick = {a[31:16], b[15:0]};
      default: pick = {a[31:16], b[31:16]};
    endcase
  endfunction

  // Issues still in flight other than the one being captured this cycle.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < MUL_LATENCY - 1; i++) pending = pending | tag_v[i];
  end

  always_comb begin
    case (tag_k[MUL_LATENCY-1])
      2'd0:       addend = ACC_W'(mul_p);
      2'd1, 2'd2: addend = ACC_W'({mul_p, 16'h0000});
      default:    addend = ACC_W'({mul_p, 32'h0000_0000});
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      step      <= '0;
      acc       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_en    <= 1'b0;
      for (int i = 0; i < MUL_LATENCY; i++) begin
        tag_v[i] <= 1'b0;
        tag_k[i] <= 2'd0;
      end
    end else begin
      for (int i = MUL_LATENCY - 1; i > 0; i--) begin
        tag_v[i] <= tag_v[i-1];
        tag_k[i] <= tag_k[i-1];
      end
      tag_v[0] <= (state == ISSUE);
      tag_k[0] <= step;

      if (tag_v[MUL_LATENCY-1]) acc <= acc + addend;

      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q            <= in_a;
            b_q            <= in_b;
            acc            <= '0;
            step           <= 2'd0;
            {mul_a, mul_b} <= pick(2'd0, in_a, in_b);
            mul_en         <= 1'b1;
            in_ready       <= 1'b0;
            busy           <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          if (step == LAST_STEP) begin
            mul_a <= '0;
            mul_b <= '0;
            state <= DRAIN;
          end else begin
            step           <= step + 2'd1;
            {mul_a, mul_b} <= pick(step + 2'd1, a_q, b_q);
          end
        end
        DRAIN: begin
          if (!pending) begin
            mul_en    <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_lo = acc[31:0];
`ifdef MUL_SEQ_HIGH_EN
  assign out_hi = acc[63:32];
`else
  assign out_hi = 32'h0000_0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_seq_ctrl
// Description : Directed self-checking bench for mul_seq_ctrl at latency 1 and 3.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mul_seq_ctrl;

`ifdef MUL_SEQ_HIGH_EN
  localparam int N    = 4;
  localparam bit HIGH = 1'b1;
`else
  localparam int N    = 3;
  localparam bit HIGH = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, out_ready;
  logic [31:0] in_a, in_b;

  logic        in_valid, in_ready, out_valid, busy, mul_en;
  logic [31:0] out_lo, out_hi;
  logic [15:0] mul_a, mul_b;
  logic [31:0] mul_p = 32'h0;

  logic        in_valid3, in_ready3, out_valid3, busy3, mul_en3;
  logic [31:0] out_lo3, out_hi3, mul_p3;
  logic [15:0] mul_a3, mul_b3;
  logic [31:0] pipe3 [3] = '{32'h0, 32'h0, 32'h0};

  int total = 0;
  int bad   = 0;

  mul_seq_ctrl #(.MUL_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_lo(out_lo), .out_hi(out_hi), .busy(busy), .mul_a(mul_a),
    .mul_b(mul_b), .mul_en(mul_en), .mul_p(mul_p)
  );

  mul_seq_ctrl #(.MUL_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid3), .out_ready(out_ready),
    .out_lo(out_lo3), .out_hi(out_hi3), .busy(busy3), .mul_a(mul_a3),
    .mul_b(mul_b3), .mul_en(mul_en3), .mul_p(mul_p3)
  );

  // Registered multiplier cells advancing only while enabled.
  always @(posedge clk) if (mul_en) mul_p <= 32'(mul_a) * 32'(mul_b);
  always @(posedge clk) if (mul_en3) begin
    pipe3[0] <= 32'(mul_a3) * 32'(mul_b3);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign mul_p3 = pipe3[2];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents operands for one cycle; returns just after the accept edge (cycle 1).
  task automatic accept(input logic [31:0] a, input logic [31:0] b, input bit use3);
    @(negedge clk);
    in_a = a;
    in_b = b;
    if (use3) in_valid3 = 1'b1; else in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_valid3 = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    total++; if ({in_ready, out_valid, busy, mul_en} !== 4'b1000) begin bad++;
      $display("FAIL reset_ctl got=%b want=1000", {in_ready, out_valid, busy, mul_en}); end
    total++; if ({mul_a, mul_b} !== 32'h0) begin bad++;
      $display("FAIL reset_mulop got=%h want=0", {mul_a, mul_b}); end
    total++; if ({out_hi, out_lo} !== 64'h0) begin bad++;
      $display("FAIL reset_out got=%h want=0", {out_hi, out_lo}); end
    total++; if ({in_ready3, out_valid3, busy3, mul_en3} !== 4'b1000) begin bad++;
      $display("FAIL reset_ctl3 got=%b want=1000", {in_ready3, out_valid3, busy3, mul_en3}); end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    logic [31:0] ops [4];
    int cyc;
    ops[0] = {16'h0002, 16'h0004};
    ops[1] = {16'h0002, 16'h0003};
    ops[2] = {16'h0001, 16'h0004};
    ops[3] = {16'h0001, 16'h0003};
    accept(32'h0001_0002, 32'h0003_0004, 1'b0);
    cyc = 1;
    for (int k = 0; k < N; k++) begin
      total++; if ({mul_en, busy, in_ready, mul_a, mul_b} !== {3'b110, ops[k]}) begin bad++;
        $display("FAIL issue_step%0d got=%h want=%h", k, {mul_en, busy, in_ready, mul_a, mul_b}, {3'b110, ops[k]}); end
      tick(); cyc++;
    end
    total++; if ({mul_en, mul_a, mul_b} !== 33'h1_0000_0000) begin bad++;
      $display("FAIL drain_ops got=%h want=100000000", {mul_en, mul_a, mul_b}); end
    while (!out_valid && cyc < 40) begin tick(); cyc++; end
    total++; if (cyc !== N + 2) begin bad++;
      $display("FAIL basic_latency got=%0d want=%0d", cyc, N + 2); end
    total++; if (out_lo !== 32'h000A_0008) begin bad++;
      $display("FAIL basic_lo got=%h want=000a0008", out_lo); end
    total++; if (out_hi !== (HIGH ? 32'h3 : 32'h0)) begin bad++;
      $display("FAIL basic_hi got=%h want=%h", out_hi, (HIGH ? 32'h3 : 32'h0)); end
    tick();
    total++; if ({in_ready, out_valid, busy} !== 3'b100) begin bad++;
      $display("FAIL basic_idle got=%b want=100", {in_ready, out_valid, busy}); end
  endtask

  task automatic test_allones;
    int cyc;
    accept(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    cyc = 1;
    while (!out_valid && cyc < 40) begin tick(); cyc++; end
    total++; if (cyc !== N + 2) begin bad++;
      $display("FAIL ones_latency got=%0d want=%0d", cyc, N + 2); end
    total++; if (out_lo !== 32'h0000_0001) begin bad++;
      $display("FAIL ones_lo got=%h want=00000001", out_lo); end
    total++; if (out_hi !== (HIGH ? 32'hFFFF_FFFE : 32'h0)) begin bad++;
      $display("FAIL ones_hi got=%h want=%h", out_hi, (HIGH ? 32'hFFFF_FFFE : 32'h0)); end
    tick();
  endtask

  task automatic test_hold;
    int cyc;
    out_ready = 1'b0;
    accept(32'h0000_1234, 32'h0000_0010, 1'b0);
    cyc = 1;
    while (!out_valid && cyc < 40) begin tick(); cyc++; end
    for (int h = 0; h < 4; h++) begin
      total++; if ({out_valid, in_ready, mul_en, busy, out_lo, out_hi} !== {4'b1001, 32'h0001_2340, 32'h0}) begin bad++;
        $display("FAIL hold_cyc%0d got=%b/%h/%h want=1001/00012340/0", h,
                 {out_valid, in_ready, mul_en, busy}, out_lo, out_hi); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    total++; if ({in_ready, out_valid, busy} !== 3'b100) begin bad++;
      $display("FAIL hold_release got=%b want=100", {in_ready, out_valid, busy}); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    accept(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    total++; if ({in_ready, out_valid, busy, mul_en, mul_a, mul_b, out_lo, out_hi} !== {4'b1000, 96'h0}) begin bad++;
      $display("FAIL midreset_outs got=%b/%h/%h/%h want=1000/0/0/0",
               {in_ready, out_valid, busy, mul_en}, {mul_a, mul_b}, out_lo, out_hi); end
    @(negedge clk);
    reset = 1'b0;
    tick(); tick();
    accept(32'd2, 32'd3, 1'b0);
    cyc = 1;
    while (!out_valid && cyc < 40) begin tick(); cyc++; end
    total++; if (cyc !== N + 2) begin bad++;
      $display("FAIL midreset_latency got=%0d want=%0d", cyc, N + 2); end
    total++; if ({out_hi, out_lo} !== 64'd6) begin bad++;
      $display("FAIL midreset_result got=%h want=6", {out_hi, out_lo}); end
    tick();
  endtask

  task automatic test_latency3;
    int cyc;
    accept(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    for (cyc = 1; cyc <= N + 3; cyc++) begin
      total++; if ({mul_en3, out_valid3} !== 2'b10) begin bad++;
        $display("FAIL lat3_cyc%0d en/valid got=%b want=10", cyc, {mul_en3, out_valid3}); end
      tick();
    end
    total++; if ({mul_en3, out_valid3} !== 2'b01) begin bad++;
      $display("FAIL lat3_done en/valid got=%b want=01", {mul_en3, out_valid3}); end
    total++; if (out_lo3 !== 32'h242D_2080) begin bad++;
      $display("FAIL lat3_lo got=%h want=242d2080", out_lo3); end
    tick();
    total++; if (in_ready3 !== 1'b1) begin bad++;
      $display("FAIL lat3_idle got=%b want=1", in_ready3); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    int hits;
    hits = 0;
    @(negedge clk);
    in_a = 32'd7; in_b = 32'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = 32'h0001_0000; in_b = 32'h0001_0000;
    for (cyc = 1; cyc <= 2 * N + 8; cyc++) begin
      if (cyc == N + 4) in_valid = 1'b0;
      if (out_valid) begin
        hits++;
        if (hits == 1) begin
          total++; if (cyc !== N + 2 || out_lo !== 32'd63 || out_hi !== 32'h0) begin bad++;
            $display("FAIL b2b_first got=cyc%0d %h_%h want=cyc%0d 0_3f", cyc, out_hi, out_lo, N + 2); end
        end else if (hits == 2) begin
          total++; if (cyc !== 2 * N + 5 || out_lo !== 32'h0 || out_hi !== (HIGH ? 32'h1 : 32'h0)) begin bad++;
            $display("FAIL b2b_second got=cyc%0d %h_%h want=cyc%0d %h_0", cyc, out_hi, out_lo,
                     2 * N + 5, (HIGH ? 32'h1 : 32'h0)); end
        end
      end
      tick();
    end
    in_valid = 1'b0;
    total++; if (hits !== 2) begin bad++;
      $display("FAIL b2b_count got=%0d want=2", hits); end
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    in_valid3 = 1'b0;
    in_a      = 32'h0;
    in_b      = 32'h0;
    test_reset();
    test_basic();
    test_allones();
    test_hold();
    test_reset_mid();
    test_latency3();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequencing controller that computes an unsigned 32x32 product by time-multiplexing one external registered 16x16 unsigned multiplier cell. It accepts operands over a valid/ready handshake, issues the partial products lo*lo, lo*hi, hi*lo (plus hi*hi when configured) to the cell, and accumulates the returned products. It returns the result over a second valid/ready handshake. It sits between a CPU-side custom-instruction or accelerator front end and a shared DSP multiplier cell.

## Interface
- MUL_LATENCY, 1: cycles from a cell issue with mul_en=1 to its product on mul_p; legal 1..3.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept operands; high only in IDLE.
- in_a  in  32  multiplicand, unsigned.
- in_b  in  32  multiplier, unsigned.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  consumer accepts result.
- out_lo  out  32  product bits [31:0].
- out_hi  out  32  product bits [63:32]; constant 0 without MUL_SEQ_HIGH_EN.
- busy  out  1  high in every state except IDLE.
- mul_a  out  16  cell operand A.
- mul_b  out  16  cell operand B.
- mul_en  out  1  cell pipeline enable.
- mul_p  in  32  cell product, MUL_LATENCY enabled cycles after issue.

## Operation
- States: IDLE, ISSUE (N cycles, N=3, or 4 with macro), DRAIN (MUL_LATENCY cycles), DONE.
- IDLE: in_ready=1. On in_valid, latch in_a/in_b, clear accumulator, go to ISSUE.
- ISSUE step k drives mul_a/mul_b as follows: k0 a[15:0]*b[15:0], k1 a[15:0]*b[31:16], k2 a[31:16]*b[15:0], k3 a[31:16]*b[31:16] (macro only). Each step pushes a tag (k, valid) into a MUL_LATENCY-deep tag shift register.
- DRAIN: mul_a=mul_b=0. No tag is pushed. Go to DONE when the shift register is empty.
- The shift-register output tag selects the accumulate operation on mul_p: k0 +p, k1/k2 +(p<<16), k3 +(p<<32).
- The accumulator is 32 bits (mod 2^32) without the macro and 64 bits (mod 2^64) with it. Carries out of the top bit are discarded.
- mul_en=1 throughout ISSUE and DRAIN so that the cell pipeline advances. mul_en=0 in IDLE and DONE.
- DONE: out_valid=1, with out_lo/out_hi driven from the accumulator and stable. When out_ready=1, go to IDLE. Operands are accepted only in IDLE; a new operation cannot overlap the output cycle.
- in_a/in_b changes after acceptance have no effect.
- Reset, including mid-operation: state returns to IDLE, the tag shift register and accumulator are cleared, and any in-flight cell products are ignored.

## Timing
- Reset values: in_ready=1 and out_valid=0 (IDLE state); out_lo=out_hi=0, mul_a=mul_b=0, mul_en=0, busy=0.
- Accept edge at cycle 0. Issues occur in cycles 1..N. Captures occur in cycles 1+MUL_LATENCY..N+MUL_LATENCY. out_valid rises in cycle N+MUL_LATENCY+1.
- With MUL_LATENCY=1, latency is 5 cycles, or 6 with the macro.
- With out_ready tied high and in_valid held high, the initiation interval is N+MUL_LATENCY+2 cycles: 6 cycles, or 7 with the macro.
- All outputs are registered. There is no combinational path from in_valid or out_ready to any output.

## Configuration
- MUL_SEQ_HIGH_EN defined: the k3 hi*hi step is issued, the accumulator is 64 bits, and out_hi carries product bits [63:32].
- MUL_SEQ_HIGH_EN undefined: there are 3 issue steps, the accumulator is 32 bits, and out_hi=0. This is the low-word multiply only.

## Test plan
- With MUL_LATENCY=1 and no macro, in_a=0x00010002, in_b=0x00030004 -> out_lo=0x000A0008, out_hi=0, out_valid in cycle 5.
- With the macro, in_a=in_b=0xFFFFFFFF -> out_hi=0xFFFFFFFE, out_lo=0x00000001, out_valid in cycle 6. Without the macro -> out_lo=0x00000001.
- Hold out_ready=0 for 4 cycles in DONE -> out_lo/out_hi stable, in_ready=0, mul_en=0. On out_ready=1, IDLE the next cycle with in_ready=1.
- Assert reset during the second ISSUE cycle -> all outputs at reset values immediately. After release, operands 2*3 -> out_lo=6, with no contamination from the aborted operation.
- With MUL_LATENCY=3, in_a=0x12345678, in_b=0x9ABCDEF0 -> out_lo=0x242D2080, out_valid in cycle 7 (no macro). mul_en high in cycles 1..6.
- Back-to-back operations with out_ready=1: operands (7,9) then (0x10000,0x10000) -> out_lo=63 then 0 (out_hi=1 with macro), with accept edges 6 cycles apart (7 with macro).
